psum_acc: RTL and testbench
===========================

PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001: Parameter col, default 8, number of output lanes per ofifo vector.
REQ-002: Parameter psum_bw, default 16, signed partial-sum width per lane.
REQ-003: Parameter n_out, default 16, vectors per kij pass; psum SRAM depth.
REQ-004: Parameter n_kij, default 9, kernel positions per output tile.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: reset  input  1  one clock; reset is synchronous and active-low.
REQ-007: start  input  1  one-cycle request to process one kij pass.
REQ-008: kij  input  4  kernel index of the pass, sampled when start is accepted.
REQ-009: relu_en  input  1  apply ReLU on the final pass, sampled with start.
REQ-010: of_valid  input  1  ofifo head vector available.
REQ-011: of_out  input  col*psum_bw  ofifo head vector, show-ahead, lane i at bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-012: of_rd  output  1  ofifo pop strobe.
REQ-013: P_Q  input  col*psum_bw  psum SRAM read data, valid one cycle after a read.
REQ-014: P_D  output  col*psum_bw  psum SRAM write data.
REQ-015: P_A  output  log2(n_out)  psum SRAM address.
REQ-016: P_CEN  output  1  SRAM chip enable, active-low.
REQ-017: P_WEN  output  1  SRAM write enable, active-low (0 = write).
REQ-018: busy  output  1  high from start acceptance until done.
REQ-019: done  output  1  one-cycle pulse after the last write of a pass.

Function
REQ-020: FSM states IDLE, FETCH, SRD, ACC, SWR, DONE.
REQ-021: IDLE: start=1 latches kij and relu_en, clears vector counter cnt, enters FETCH, busy=1 next cycle; start while not IDLE is ignored.
REQ-022: FETCH: of_valid=0 -> hold, of_rd=0; of_valid=1 -> of_rd=1 for exactly that cycle, of_out captured into vec, next state SRD if kij!=0 else SWR.
REQ-023: SRD: P_CEN=0, P_WEN=1, P_A=cnt for one cycle; next ACC.
REQ-024: ACC: per lane sum = vec + P_Q, signed psum_bw, two's-complement wrap on overflow (no saturation); next SWR.
REQ-025: kij==0: sum = vec, SRAM not read (overwrites stale contents).
REQ-026: kij==n_kij-1 and latched relu_en=1: each negative lane of sum forced to 0 before write; otherwise no clamp.
REQ-027: kij values >= n_kij behave as accumulate without ReLU.
REQ-028: SWR: P_CEN=0, P_WEN=0, P_A=cnt, P_D=sum for one cycle; cnt==n_out-1 -> DONE, else cnt+1, FETCH.
REQ-029: DONE: done=1 one cycle, busy=0 next cycle, return to IDLE.
REQ-030: Outside SRD/SWR P_CEN=1, P_WEN=1; P_A and P_D hold last driven value.
REQ-031: Throughput: 4 cycles/vector for kij!=0, 2 for kij==0, plus FETCH stalls; pass with no stalls takes 4*n_out+1 cycles from start to done (2*n_out+1 for kij==0).
REQ-032: of_rd never asserted when of_valid=0; at most one pop per vector.
REQ-033: Counter wraps to 0 only via IDLE start; no SRAM access beyond n_out-1.

Reset
REQ-034: reset=0 at a rising edge forces IDLE, cnt=0, vec=0, of_rd=0, P_CEN=1, P_WEN=1, P_A=0, P_D=0, busy=0, done=0.
REQ-035: Reset mid-pass aborts without issuing any further SRAM access or pop; partial SRAM contents are not restored.
REQ-036: start sampled with reset=0 is dropped.

Verification
REQ-037: kij=0, of_out lanes all 5, 16 vectors, of_valid=1 continuously -> 16 writes of 5 per lane to addr 0..15, done at cycle 33.
REQ-038: kij=0 then kij=1..8 each with lane value 3, relu_en=0 -> final SRAM lanes 27, done pulse per pass.
REQ-039: Final pass kij=8, relu_en=1, SRAM lane -10, of_out lane +4 -> written 0; SRAM lane 10, of_out -4 -> 6.
REQ-040: Overflow: SRAM lane 0x7FFF + of_out 1, kij=3 -> writes 0x8000.
REQ-041: of_valid toggled 0/1 randomly -> of_rd only when of_valid=1, exactly 16 pops, results identical to no-stall run.
REQ-042: reset=0 asserted during SWR of vector 7 -> P_CEN=1, of_rd=0, busy=0 next cycle; start ignored while reset=0; subsequent kij=0 pass completes normally.

Source files
------------

// File: rtl/psum_acc.sv
// psum_acc: partial-sum accumulator between the output FIFO and the psum SRAM.
// For each kij pass it walks n_out vectors. Each vector is popped, added lane-wise
// to the stored partial sum (kij==0 overwrites instead), optionally clamped by
// ReLU on the final kernel position, and written back.

// One lane: signed wrap-around add with an optional negative clamp.
module psum_acc_lane #(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] a,
   input  logic [psum_bw-1:0] q,
   input  logic               add_en,
   input  logic               clamp,
   output logic [psum_bw-1:0] sum
);

   logic signed [psum_bw-1:0] s;

   // add (or pass through on the first kernel position), then clamp negatives
   always_comb begin
      s   = add_en ? ($signed(a) + $signed(q)) : $signed(a);
      sum = (clamp && s[psum_bw-1]) ? '0 : s;
   end

endmodule

module psum_acc #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int n_out   = 16,
   parameter int n_kij   = 9,
   localparam int aw     = (n_out > 1) ? $clog2(n_out) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             kij,
   input  logic                   relu_en,
   input  logic                   of_valid,
   input  logic [col*psum_bw-1:0] of_out,
   output logic                   of_rd,
   input  logic [col*psum_bw-1:0] P_Q,
   output logic [col*psum_bw-1:0] P_D,
   output logic [aw-1:0]          P_A,
   output logic                   P_CEN,
   output logic                   P_WEN,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {IDLE, FETCH, SRD, ACC, SWR, DONE} state_t;

   localparam logic [3:0]    last_kij = 4'(n_kij - 1);
   localparam logic [aw-1:0] last_cnt = aw'(n_out - 1);

   state_t                   state;
   logic [aw-1:0]            cnt;
   logic [col*psum_bw-1:0]   vec;
   logic [3:0]               kij_q;
   logic                     relu_q;

   logic [col-1:0][psum_bw-1:0] lane_a, lane_q, lane_sum;
   logic                        add_en, clamp;

   // kij==0 writes straight from the FIFO head in FETCH; otherwise the captured
   // vector is summed with SRAM read data during ACC
   assign lane_a = (state == FETCH) ? of_out : vec;
   assign lane_q = P_Q;
   assign add_en = (state == ACC);
   assign clamp  = relu_q && (kij_q == last_kij);

   // show-ahead FIFO: pop in the same cycle the head is captured
   assign of_rd  = (state == FETCH) && of_valid;

   for (genvar i = 0; i < col; i++) begin : g_lane
      psum_acc_lane #(.psum_bw(psum_bw)) u_lane (
         .a      (lane_a[i]),
         .q      (lane_q[i]),
         .add_en (add_en),
         .clamp  (clamp),
         .sum    (lane_sum[i])
      );
   end

   // pass sequencer; SRAM controls are registered so they line up with the state they belong to
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         vec    <= '0;
         kij_q  <= '0;
         relu_q <= 1'b0;
         P_CEN  <= 1'b1;
         P_WEN  <= 1'b1;
         P_A    <= '0;
         P_D    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               kij_q  <= kij;
               relu_q <= relu_en;
               cnt    <= '0;
               busy   <= 1'b1;
               state  <= FETCH;
            end
            FETCH: if (of_valid) begin
               vec   <= of_out;
               P_CEN <= 1'b0;
               P_A   <= cnt;
               if (kij_q != '0) begin
                  P_WEN <= 1'b1;
                  state <= SRD;
               end else begin
                  P_WEN <= 1'b0;
                  P_D   <= lane_sum;
                  state <= SWR;
               end
            end
            SRD: begin
               P_CEN <= 1'b1;
               state <= ACC;
            end
            ACC: begin
               P_CEN <= 1'b0;
               P_WEN <= 1'b0;
               P_D   <= lane_sum;
               state <= SWR;
            end
            SWR: begin
               P_CEN <= 1'b1;
               P_WEN <= 1'b1;
               if (cnt == last_cnt) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= FETCH;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: FIFO and SRAM models, reference accumulator, write scoreboard.
module tb_psum_acc;

   localparam int COL = 8, BW = 16, NOUT = 16, NKIJ = 9, W = COL * BW;

   logic          clk = 1'b0, reset = 1'b0, start = 1'b0, relu_en = 1'b0, of_valid = 1'b0;
   logic [3:0]    kij = '0;
   logic [W-1:0]  of_out = '0, P_Q = '0;
   logic          of_rd, P_CEN, P_WEN, busy, done;
   logic [W-1:0]  P_D;
   logic [3:0]    P_A;

   int errors = 0, checks = 0, pops = 0;
   bit stall_mode = 1'b0;

   logic [W-1:0] mem [NOUT];
   logic [W-1:0] ref_mem [NOUT];
   logic [W-1:0] pv [NOUT];
   logic [W-1:0] fq [$];

   typedef struct packed {logic [3:0] a; logic [W-1:0] d;} wr_t;
   wr_t sb [$];

   psum_acc #(.col(COL), .psum_bw(BW), .n_out(NOUT), .n_kij(NKIJ)) dut (
      .clk(clk), .reset(reset), .start(start), .kij(kij), .relu_en(relu_en),
      .of_valid(of_valid), .of_out(of_out), .of_rd(of_rd), .P_Q(P_Q), .P_D(P_D),
      .P_A(P_A), .P_CEN(P_CEN), .P_WEN(P_WEN), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] old, input logic [W-1:0] v,
                                          input int k, input bit relu);
      logic [W-1:0] r;
      logic signed [BW-1:0] s;
      r = '0;
      for (int i = 0; i < COL; i++) begin
         s = v[i*BW +: BW];
         if (k != 0) s = s + $signed(old[i*BW +: BW]);
         if (relu && k == NKIJ - 1 && s < 0) s = '0;
         r[i*BW +: BW] = s;
      end
      return r;
   endfunction

   // psum SRAM: one-cycle read latency
   always @(posedge clk) begin
      if (!P_CEN) begin
         if (!P_WEN) mem[P_A] <= P_D;
         else        P_Q <= mem[P_A];
      end
   end

   // FIFO pop side
   always @(posedge clk) begin
      if (of_rd) begin
         chk("pop_valid", of_valid, 1'b1);
         if (fq.size() > 0) void'(fq.pop_front());
         pops++;
      end
   end

   // FIFO head presentation, randomly withheld in stall mode
   always @(negedge clk) begin
      bit gate;
      gate     = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      of_valid = gate && (fq.size() > 0);
      of_out   = (fq.size() > 0) ? fq[0] : '0;
   end

   // write scoreboard
   always @(negedge clk) begin
      if (!P_CEN && !P_WEN) begin
         chk("sb_nonempty", W'(sb.size() > 0), W'(1));
         if (sb.size() > 0) begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", W'(P_A), W'(e.a));
            chk("wr_data", P_D, e.d);
         end
      end
   end

   task automatic set_all(input logic [BW-1:0] val);
      for (int v = 0; v < NOUT; v++) pv[v] = {COL{val}};
   endtask

   task automatic set_alt(input logic [BW-1:0] ev, input logic [BW-1:0] od);
      for (int v = 0; v < NOUT; v++) pv[v] = {(COL/2){od, ev}};
   endtask

   task automatic run_pass(input int k, input bit relu, input bit stall);
      int el, p0;
      bit seen;
      for (int v = 0; v < NOUT; v++) begin
         ref_mem[v] = model(ref_mem[v], pv[v], k, relu);
         sb.push_back('{a: 4'(v), d: ref_mem[v]});
         fq.push_back(pv[v]);
      end
      stall_mode = stall;
      p0 = pops;
      @(negedge clk);
      kij = 4'(k); relu_en = relu; start = 1'b1;
      el = 0; seen = 1'b0;
      while (!seen && el < 2000) begin
         @(negedge clk);
         el++;
         if (el == 1) begin
            kij = 4'(k) ^ 4'h5; relu_en = ~relu;
            chk("busy_on", busy, 1'b1);
         end
         start = (el == 5);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", seen, 1'b1);
      if (!stall) chk("latency", el, (k == 0) ? 33 : 65);
      chk("busy_in_done", busy, 1'b1);
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("busy_off", busy, 1'b0);
      chk("pops", pops - p0, 16);
      chk("sb_empty", sb.size(), 0);
      stall_mode = 1'b0;
   endtask

   initial begin
      int n;
      for (int v = 0; v < NOUT; v++) ref_mem[v] = '0;
      // reset state
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cen", P_CEN, 1'b1);
      chk("rst_wen", P_WEN, 1'b1);
      chk("rst_pa", P_A, 0);
      chk("rst_pd", P_D, '0);
      chk("rst_ofrd", of_rd, 1'b0);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_start_dropped", busy, 1'b0);

      // first pass overwrites with lane value 5
      set_all(16'd5);
      run_pass(0, 1'b0, 1'b0);
      chk("ram5_a", mem[0], {COL{16'd5}});
      chk("ram5_b", mem[15], {COL{16'd5}});

      // nine-pass accumulation of 3
      set_all(16'd3);
      for (int k = 0; k < NKIJ; k++) run_pass(k, 1'b0, 1'b0);
      chk("ram27_a", mem[0], {COL{16'd27}});
      chk("ram27_b", mem[15], {COL{16'd27}});

      // ReLU on the final kernel position
      set_alt(16'hFFF6, 16'd10);
      run_pass(0, 1'b0, 1'b0);
      set_alt(16'd4, 16'hFFFC);
      run_pass(8, 1'b1, 1'b0);
      chk("relu_mix", mem[3], {(COL/2){16'd6, 16'd0}});

      // out-of-range kij accumulates and never clamps
      set_all(16'hFFF6);
      run_pass(0, 1'b0, 1'b0);
      set_all(16'd4);
      run_pass(12, 1'b1, 1'b0);
      chk("kij_big_noclamp", mem[7], {COL{16'hFFFA}});

      // signed wrap
      set_all(16'h7FFF);
      run_pass(0, 1'b0, 1'b0);
      set_all(16'd1);
      run_pass(3, 1'b0, 1'b0);
      chk("wrap", mem[9], {COL{16'h8000}});

      // random data with FIFO stalls
      for (int v = 0; v < NOUT; v++) pv[v] = {$urandom, $urandom, $urandom, $urandom};
      run_pass(0, 1'b0, 1'b0);
      for (int v = 0; v < NOUT; v++) pv[v] = {$urandom, $urandom, $urandom, $urandom};
      run_pass(5, 1'b0, 1'b1);
      chk("stall_ram", mem[11], ref_mem[11]);

      // reset during the write of vector 7
      set_all(16'd2);
      for (int v = 0; v < NOUT; v++) begin
         fq.push_back(pv[v]);
         if (v <= 7) begin
            ref_mem[v] = model(ref_mem[v], pv[v], 1, 1'b0);
            sb.push_back('{a: 4'(v), d: ref_mem[v]});
         end
      end
      @(negedge clk);
      kij = 4'd1; relu_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(!P_CEN && !P_WEN && P_A == 4'd7) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_swr7", W'(n < 200), W'(1));
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      chk("abort_cen", P_CEN, 1'b1);
      chk("abort_ofrd", of_rd, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_pa", P_A, 0);
      @(negedge clk);
      chk("abort_busy2", busy, 1'b0);
      reset = 1'b1; start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ofrd", of_rd, 1'b0);
         chk("idle_cen", P_CEN, 1'b1);
         chk("idle_busy", busy, 1'b0);
      end
      chk("abort_fifo_left", fq.size(), 8);
      chk("abort_sb_empty", sb.size(), 0);
      fq.delete();
      @(negedge clk);

      // clean pass after the abort
      set_all(16'd9);
      run_pass(0, 1'b0, 1'b0);
      chk("post_abort_ram", mem[12], {COL{16'd9}});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
